line_buffer_ctrl: RTL and testbench
===================================

# line_buffer_ctrl

Sequencer for the binary line buffer: accepts a raster-order 1-bit pixel stream through a valid/ready handshake, generates the column address and write enable for the line RAMs, tracks row/column position, and flags the cycles where a complete WindowSize×WindowSize window ends at the current pixel. It sits between the pixel source and the line buffer + window assembler, one instance per image pipeline.

## Interface
- ImageWidth, 7, pixels per row
- ImageHeight, 7, rows per frame
- WindowSize, 3, window edge length; legal range is 2..min(ImageWidth, ImageHeight)
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a frame when idle
- Stall  in  1  downstream back-pressure; holds all state
- InValid  in  1  pixel present on InData
- InData  in  1  pixel value
- InReady  out  1  controller accepts pixel this cycle
- WriteEnable  out  1  line buffer write strobe
- Addr  out  $clog2(ImageWidth+1)  line buffer column address
- Data  out  1  pixel to line buffer (InData passthrough)
- Column  out  $clog2(ImageWidth+1)  column of current accepted pixel
- Row  out  $clog2(ImageHeight+1)  row of current accepted pixel
- WindowValid  out  1  window ending at (Row, Column) is complete
- Busy  out  1  frame in progress
- FrameDone  out  1  one-cycle pulse after last pixel written

## Operation
- States: IDLE, FILL (Row < WindowSize-1), RUN (Row ≥ WindowSize-1), DONE.
- IDLE: InReady=0. Start → FILL with column and row counters at 0. Start in any other state is ignored.
- Accept: Accept = InValid & InReady. InReady = (state is FILL or RUN) & ~Stall.
- WriteEnable = Accept; Data = InData; Addr = Column. All three are combinational from the current counter and state.
- On Accept, the column counter increments. At ImageWidth-1 it wraps to 0 and the row counter increments.
- FILL → RUN on the Accept that wraps row WindowSize-2.
- Accept of pixel (ImageHeight-1, ImageWidth-1) → DONE.
- DONE: FrameDone=1 for exactly one cycle, then IDLE. Busy=0 in IDLE only.
- WindowValid = Accept & Row ≥ WindowSize-1 & Column ≥ WindowSize-1. Windows per frame = (ImageWidth-WindowSize+1)·(ImageHeight-WindowSize+1).
- Stall: no Accept, counters frozen, state unchanged. Stall in IDLE or DONE has no effect.
- InValid low during FILL or RUN is a bubble: state is held and no write occurs.
- Reset: state IDLE; counters 0; InReady, WriteEnable, WindowValid, Busy and FrameDone all 0. Reset mid-frame discards the frame. Reset wins over a simultaneous Start or Accept.
- Counter comparisons use the full counter widths. Counters never reach ImageWidth or ImageHeight.

## Timing
- Zero-latency write path: a pixel accepted in cycle t is written at Addr=Column in cycle t.
- Counters update on the clock edge that ends cycle t.
- Start in cycle t → InReady can be 1 in cycle t+1.
- FrameDone is asserted in the cycle after the final Accept. The earliest next Start is accepted in the cycle after FrameDone (state is IDLE).
- WindowValid is aligned with the write cycle. Any line RAM read latency is compensated downstream by the window assembler, not here.
- Uninterrupted frame with InValid held high: ImageWidth·ImageHeight accept cycles, plus 1 DONE cycle, plus 1 cycle Start→FILL.

## Structure
- Shared package holds:
  - state enum {IDLE, FILL, RUN, DONE}
  - width functions AddrWidth = $clog2(ImageWidth+1) and RowWidth = $clog2(ImageHeight+1), shared with the line buffer and window assembler.
- Sub-module wrap_counter is parameterised by modulus and has Clock, Reset, Enable, Count and Wrap ports. It is instantiated twice: column (Enable=Accept) and row (Enable=column Wrap).
- FSM and output decode live in line_buffer_ctrl itself.

## Test plan
- Reset then idle: all outputs 0. InValid=1 without Start → no WriteEnable, InReady=0.
- Start, 49 pixels with InValid held (7×7, n=3) → 49 WriteEnable, 25 WindowValid with the first at Row=2/Column=2, FrameDone one cycle after the 49th Accept, Busy drops with it.
- Addr wrap: Addr sequence 0..6,0; Row increments only on the write after Addr=6. FILL→RUN transition happens when Row becomes 2.
- Stall for 3 cycles at Row=3/Column=4 → InReady=0, no writes, counters hold. Resumes at Column=4 with no skipped or duplicated pixels.
- Start pulsed at Row=1 mid-frame → ignored. Counters and the frame continue unchanged.
- Reset asserted at Row=4/Column=2 together with InValid → no write that cycle, IDLE next cycle. A new Start then produces a full 49-pixel frame from Row=0/Column=0.

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and width helpers for the binary line buffer pipeline
// (controller, line RAMs, window assembler).
package line_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned addr_width(input int unsigned image_width);
    return $clog2(image_width + 1);
  endfunction

  function automatic int unsigned row_width(input int unsigned image_height);
    return $clog2(image_height + 1);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_wrap_counter.sv
// Modulo counter: advances on enable, wraps to 0 after Modulus-1 with a
// combinational wrap strobe in the wrapping cycle.
module line_buffer_ctrl_wrap_counter #(
  parameter int unsigned Modulus = 7,
  parameter int unsigned Width   = $clog2(Modulus + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             wrap
);

  logic [Width-1:0] count_q, count_d;

  assign wrap  = enable & (count_q == Width'(Modulus - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: accepts a raster 1-bit pixel stream, drives the line RAM
// write port and flags pixels that complete a WindowSize x WindowSize window.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int unsigned ImageWidth  = 7,
  parameter int unsigned ImageHeight = 7,
  parameter int unsigned WindowSize  = 3,
  localparam int unsigned AddrW      = addr_width(ImageWidth),
  localparam int unsigned RowW       = row_width(ImageHeight)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            in_valid,
  input  logic            in_data,
  output logic            in_ready,
  output logic            write_enable,
  output logic [AddrW-1:0] addr,
  output logic            data,
  output logic [AddrW-1:0] column,
  output logic [RowW-1:0]  row,
  output logic            window_valid,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [RowW-1:0]  FillLastRow = RowW'(WindowSize - 2);
  localparam logic [RowW-1:0]  WinMinRow   = RowW'(WindowSize - 1);
  localparam logic [AddrW-1:0] WinMinCol   = AddrW'(WindowSize - 1);

  state_e state_q, state_d;
  logic   accept;
  logic   col_wrap;
  logic   row_wrap;

  line_buffer_ctrl_wrap_counter #(
    .Modulus(ImageWidth),
    .Width  (AddrW)
  ) u_col_cnt (
    .clock (clock),
    .reset (reset),
    .enable(accept),
    .count (column),
    .wrap  (col_wrap)
  );

  line_buffer_ctrl_wrap_counter #(
    .Modulus(ImageHeight),
    .Width  (RowW)
  ) u_row_cnt (
    .clock (clock),
    .reset (reset),
    .enable(col_wrap),
    .count (row),
    .wrap  (row_wrap)
  );

  // Reset is folded into the handshake so a reset cycle never writes the RAM.
  assign in_ready     = ((state_q == StFill) | (state_q == StRun)) & ~stall & ~reset;
  assign accept       = in_valid & in_ready;
  assign write_enable = accept;
  assign data         = in_data;
  assign addr         = column;
  assign window_valid = accept & (row >= WinMinRow) & (column >= WinMinCol);
  assign busy         = (state_q != StIdle) & ~reset;
  assign frame_done   = (state_q == StDone) & ~reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StFill;
      StFill: if (col_wrap && (row == FillLastRow)) state_d = StRun;
      StRun:  if (row_wrap) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a 7x7 image with a 3x3 window.
module tb_line_buffer_ctrl;

  localparam int W = 7;
  localparam int H = 7;
  localparam int N = 3;

  logic       clock = 1'b0;
  logic       reset, start, stall, in_valid, in_data;
  logic       in_ready, write_enable, data, window_valid, busy, frame_done;
  logic [2:0] addr, column, row;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  line_buffer_ctrl #(
    .ImageWidth (W),
    .ImageHeight(H),
    .WindowSize (N)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .write_enable(write_enable),
    .addr        (addr),
    .data        (data),
    .column      (column),
    .row         (row),
    .window_valid(window_valid),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, checks 1 unit later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One frame from Start. With inject set: Start pulse at (1,3), 3-cycle stall
  // at (3,4), and reset together with a valid pixel at (4,2) which ends the frame.
  task automatic run_frame(input bit inject);
    int  r = 0, c = 0, accepted = 0, stalls = 0, guard = 0;
    int  we_seen = 0, wv_seen = 0, first_r = -1, first_c = -1;
    bit  pulsed = 1'b0;
    logic pix;

    start = 1'b1; in_valid = 1'b0; stall = 1'b0; reset = 1'b0;
    #1;
    check("start_ready", in_ready, 0);
    check("start_busy", busy, 0);
    next_cycle();
    start = 1'b0;

    while (accepted < W * H && guard < 200) begin
      guard++;
      pix      = 1'(((r * W + c) % 3) == 0);
      in_valid = 1'b1;
      in_data  = pix;
      stall    = 1'b0;
      start    = 1'b0;
      reset    = 1'b0;
      if (inject && r == 3 && c == 4 && stalls < 3) stall = 1'b1;
      if (inject && r == 1 && c == 3 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (inject && r == 4 && c == 2) reset = 1'b1;
      #1;
      check("column", column, c);
      check("row", row, r);
      check("addr", addr, c);
      check("data", data, pix);
      if (reset) begin
        check("rst_we", write_enable, 0);
        check("rst_ready", in_ready, 0);
        check("rst_wv", window_valid, 0);
        next_cycle();
        reset = 1'b0;
        in_valid = 1'b1;
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", in_ready, 0);
        check("post_rst_we", write_enable, 0);
        check("post_rst_col", column, 0);
        check("post_rst_row", row, 0);
        in_valid = 1'b0;
        return;
      end
      check("busy", busy, 1);
      if (stall) begin
        check("stall_ready", in_ready, 0);
        check("stall_we", write_enable, 0);
        stalls++;
      end else begin
        check("we", write_enable, 1);
        check("wv", window_valid, int'(r >= N - 1 && c >= N - 1));
        accepted++;
        if (c == W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      if (write_enable) we_seen++;
      if (window_valid) begin
        if (wv_seen == 0) begin
          first_r = int'(row);
          first_c = int'(column);
        end
        wv_seen++;
      end
      next_cycle();
    end
    if (guard >= 200) check("frame_timeout", guard, 0);

    check("we_total", we_seen, W * H);
    check("wv_total", wv_seen, (W - N + 1) * (H - N + 1));
    check("first_wv_row", first_r, N - 1);
    check("first_wv_col", first_c, N - 1);
    if (inject) check("stall_cycles", stalls, 3);

    // DONE cycle with the source still offering data
    in_valid = 1'b1;
    #1;
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 1);
    check("done_ready", in_ready, 0);
    check("done_we", write_enable, 0);
    next_cycle();
    #1;
    check("idle_done", frame_done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
    check("idle_col", column, 0);
    check("idle_row", row, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 1'b1;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_we", write_enable, 0);
    check("rst_wv", window_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_col", column, 0);
    check("rst_row", row, 0);
    next_cycle();
    #1;
    check("idle_no_start_we", write_enable, 0);
    check("idle_no_start_col", column, 0);
    next_cycle();

    run_frame(1'b0);
    next_cycle();
    run_frame(1'b1);
    next_cycle();
    run_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
